// File: rtl/sd_cmd_rp.sv
// SPI-mode SD command engine: shifts a CRC7-protected 48-bit command frame onto DI,
// hunts DO for the response start bit and captures R1 (or R1 + 32 bits for CMD8/CMD58).
module sd_cmd_rp #(
  parameter int NCR_MAX    = 128,
  parameter int COUNT_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            index,
  input  logic [31:0]           argument,
  input  logic                  isStart,
  output logic                  isBusy,
  output logic                  isFinish,
  output logic                  isRPFinish,
  output logic                  DI,
  input  logic                  DO,
  output logic [39:0]           response,
  input  logic                  delayStart,
  input  logic [COUNT_SIZE-1:0] delayTimes,
  output logic                  delayFinish
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEND = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] RECV = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [1:0] D_IDLE  = 2'd0;
  localparam logic [1:0] D_COUNT = 2'd1;
  localparam logic [1:0] D_HOLD  = 2'd2;

  localparam int WW = $clog2(NCR_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(NCR_MAX - 1);

  // Serial CRC7 (x^7 + x^3 + 1, zero seed) over the 40 header bits, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  logic [2:0]            state_r;
  logic [46:0]           frame_r;
  logic [5:0]            bitCnt_r;
  logic [WW-1:0]         waitCnt_r;
  logic [5:0]            rxCnt_r;
  logic [38:0]           rx_r;
  logic                  isLong_r;
  logic [39:0]           header_s;
  logic [47:0]           frameNext_s;
  logic [1:0]            dState_r;
  logic [COUNT_SIZE-1:0] dCnt_r;

  assign header_s    = {2'b01, index, argument};
  assign frameNext_s = {header_s, crc7(header_s), 1'b1};

  // Command FSM: frame transmission, response hunt and capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      frame_r    <= '0;
      bitCnt_r   <= 6'd0;
      waitCnt_r  <= '0;
      rxCnt_r    <= 6'd0;
      rx_r       <= '0;
      isLong_r   <= 1'b0;
      DI         <= 1'b1;
      isBusy     <= 1'b0;
      isFinish   <= 1'b0;
      isRPFinish <= 1'b0;
      response   <= 40'd0;
    end else begin
      case (state_r)
        IDLE: begin
          DI <= 1'b1;
          if (isStart) begin
            frame_r  <= frameNext_s[46:0];
            DI       <= frameNext_s[47];
            bitCnt_r <= 6'd47;
            isLong_r <= (index == 6'd8) || (index == 6'd58);
            isBusy   <= 1'b1;
            state_r  <= SEND;
          end
        end
        SEND: begin
          if (bitCnt_r == 6'd0) begin
            DI        <= 1'b1;
            isFinish  <= 1'b1;
            waitCnt_r <= '0;
            state_r   <= WAIT;
          end else begin
            DI       <= frame_r[46];
            frame_r  <= {frame_r[45:0], 1'b1};
            bitCnt_r <= bitCnt_r - 6'd1;
          end
        end
        WAIT: begin
          // A low DO is the R1 start bit; it is bit 7 of the response, always 0.
          if (!DO) begin
            rx_r    <= '0;
            rxCnt_r <= 6'd1;
            state_r <= RECV;
          end else if (waitCnt_r == WAIT_LAST) begin
            response   <= 40'h00_0000_00FF;
            isRPFinish <= 1'b1;
            state_r    <= DONE;
          end else begin
            waitCnt_r <= waitCnt_r + WW'(1);
          end
        end
        RECV: begin
          if (rxCnt_r == (isLong_r ? 6'd39 : 6'd7)) begin
            response   <= isLong_r ? {rx_r, DO} : {32'h0, rx_r[6:0], DO};
            isRPFinish <= 1'b1;
            state_r    <= DONE;
          end else begin
            rx_r    <= {rx_r[37:0], DO};
            rxCnt_r <= rxCnt_r + 6'd1;
          end
        end
        DONE: begin
          if (!isStart) begin
            isBusy     <= 1'b0;
            isFinish   <= 1'b0;
            isRPFinish <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          DI      <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Delay counter FSM, independent of the command engine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dState_r    <= D_IDLE;
      dCnt_r      <= '0;
      delayFinish <= 1'b0;
    end else begin
      case (dState_r)
        D_IDLE: begin
          if (delayStart) begin
            dCnt_r   <= delayTimes;
            dState_r <= D_COUNT;
          end
        end
        D_COUNT: begin
          if (dCnt_r == '0) begin
            delayFinish <= 1'b1;
            dState_r    <= D_HOLD;
          end else begin
            dCnt_r <= dCnt_r - COUNT_SIZE'(1);
          end
        end
        D_HOLD: begin
          if (!delayStart) begin
            delayFinish <= 1'b0;
            dState_r    <= D_IDLE;
          end
        end
        default: begin
          delayFinish <= 1'b0;
          dState_r    <= D_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_rp.sv
// Scoreboard bench for sd_cmd_rp: stimulus pushes expected frames/responses, monitors pop and compare.
module tb_sd_cmd_rp;

  localparam int NCR = 128;
  localparam int CS  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    index = 6'd0;
  logic [31:0]   argument = 32'd0;
  logic          isStart = 1'b0;
  logic          isBusy, isFinish, isRPFinish, DI;
  logic          DO = 1'b1;
  logic [39:0]   response;
  logic          delayStart = 1'b0;
  logic [CS-1:0] delayTimes = '0;
  logic          delayFinish;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int acceptCyc = 0;

  logic [47:0] expFrameQ[$];
  logic [39:0] expRespQ[$];
  int          expLatQ[$];

  sd_cmd_rp #(.NCR_MAX(NCR), .COUNT_SIZE(CS)) dut (
    .clk(clk), .reset(reset), .index(index), .argument(argument), .isStart(isStart),
    .isBusy(isBusy), .isFinish(isFinish), .isRPFinish(isRPFinish), .DI(DI), .DO(DO),
    .response(response), .delayStart(delayStart), .delayTimes(delayTimes),
    .delayFinish(delayFinish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: CRC7 as the remainder of polynomial division by 0x89 (mod 2).
  function automatic logic [47:0] refFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    logic [46:0] r;
    hdr = {2'b01, idx, arg};
    r = {hdr, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return {hdr, r[6:0], 1'b1};
  endfunction

  // Frame monitor: collects DI after the accept edge and checks the frame and isFinish timing.
  initial begin
    logic        collecting = 1'b0;
    logic        prevBusy = 1'b0;
    int          nb = 0;
    logic [47:0] frameAcc = '0;
    logic [47:0] curExp = '0;
    forever begin
      @(negedge clk);
      if (!collecting) begin
        if (isBusy && !prevBusy) begin
          check("frame_queue_nonempty", 64'(expFrameQ.size() > 0), 64'd1);
          curExp = (expFrameQ.size() > 0) ? expFrameQ.pop_front() : 48'd0;
          acceptCyc = cyc;
          frameAcc = {47'd0, DI};
          nb = 1;
          collecting = 1'b1;
        end
      end else if (!isBusy) begin
        collecting = 1'b0;
      end else if (nb < 48) begin
        frameAcc = {frameAcc[46:0], DI};
        nb++;
        if (nb == 48) check("finish_early", 64'(isFinish), 64'd0);
      end else begin
        check("frame", 64'(frameAcc), 64'(curExp));
        check("finish_at_e48", 64'(isFinish), 64'd1);
        check("di_idle_after_frame", 64'(DI), 64'd1);
        collecting = 1'b0;
      end
      prevBusy = isBusy;
    end
  end

  // Response monitor: on the isRPFinish rise, compare the response and its latency.
  initial begin
    logic prevRP = 1'b0;
    logic [39:0] er;
    int lat;
    forever begin
      @(negedge clk);
      if (isRPFinish && !prevRP) begin
        check("resp_queue_nonempty", 64'(expRespQ.size() > 0), 64'd1);
        if (expRespQ.size() > 0) begin
          er  = expRespQ.pop_front();
          lat = expLatQ.pop_front();
          check("response", 64'(response), 64'(er));
          check("rp_latency", 64'(cyc - acceptCyc), 64'(lat));
        end
      end
      prevRP = isRPFinish;
    end
  end

  task automatic doCmd(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] frm,
                       input int nIdle, input logic [39:0] bits, input bit toMode);
    int len;
    int lat;
    logic [39:0] er;
    len = (idx == 6'd8 || idx == 6'd58) ? 40 : 8;
    if (toMode) begin
      er  = 40'hFF;
      lat = 48 + NCR;
    end else begin
      er  = (len == 40) ? bits : {32'h0, bits[7:0]};
      lat = 48 + nIdle + len;
    end
    expFrameQ.push_back(frm);
    expRespQ.push_back(er);
    expLatQ.push_back(lat);
    index = idx; argument = arg; DO = 1'b1; isStart = 1'b1;
    @(negedge clk);
    index = 6'($urandom); argument = $urandom;
    repeat (48) @(negedge clk);
    if (!toMode) begin
      for (int k = 0; k < nIdle; k++) begin DO = 1'b1; @(negedge clk); end
      for (int k = len - 1; k >= 0; k--) begin DO = bits[k]; @(negedge clk); end
      DO = 1'b1;
    end
    for (int k = 0; k < NCR + 20 && !isRPFinish; k++) @(negedge clk);
    check("rp_seen", 64'(isRPFinish), 64'd1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("busy_held", 64'(isBusy), 64'd1);
    check("finish_held", 64'(isFinish), 64'd1);
    isStart = 1'b0;
    @(negedge clk);
    check("busy_released", 64'(isBusy), 64'd0);
    check("finish_released", 64'(isFinish), 64'd0);
    check("rp_released", 64'(isRPFinish), 64'd0);
    check("response_retained", 64'(response), 64'(er));
    check("di_idle", 64'(DI), 64'd1);
  endtask

  task automatic doDelay(input int t);
    delayTimes = CS'(t); delayStart = 1'b1;
    for (int k = 0; k <= t; k++) @(negedge clk);
    check("delay_not_yet", 64'(delayFinish), 64'd0);
    delayTimes = CS'($urandom);
    @(negedge clk);
    check("delay_finish", 64'(delayFinish), 64'd1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("delay_held", 64'(delayFinish), 64'd1);
    delayStart = 1'b0;
    @(negedge clk);
    check("delay_cleared", 64'(delayFinish), 64'd0);
  endtask

  task automatic randCmd(input int nIdle);
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [39:0] b;
    case ($urandom_range(0, 3))
      0: idx = 6'd8;
      1: idx = 6'd58;
      default: idx = 6'($urandom);
    endcase
    arg = $urandom;
    b = {8'($urandom), $urandom};
    b[39] = 1'b0;
    b[7]  = 1'b0;
    doCmd(idx, arg, refFrame(idx, arg), nIdle, b, 1'b0);
  endtask

  initial begin
    logic [5:0]  ri;
    logic [31:0] ra;
    logic [47:0] rf;
    repeat (2) @(negedge clk);
    check("rst_di", 64'(DI), 64'd1);
    check("rst_busy", 64'(isBusy), 64'd0);
    check("rst_finish", 64'(isFinish), 64'd0);
    check("rst_rpfinish", 64'(isRPFinish), 64'd0);
    check("rst_response", 64'(response), 64'd0);
    check("rst_delay", 64'(delayFinish), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    doCmd(6'd0, 32'd0, 48'h400000000095, 16, 40'h01, 1'b0);
    doCmd(6'd8, 32'h1AA, 48'h48000001AA87, 8, 40'h01000001AA, 1'b0);
    doCmd(6'd17, 32'd16, refFrame(6'd17, 32'd16), 3, 40'h00, 1'b0);
    doCmd(6'd55, 32'hDEADBEEF, refFrame(6'd55, 32'hDEADBEEF), 0, 40'h0, 1'b1);
    doCmd(6'd13, 32'h0, refFrame(6'd13, 32'h0), NCR - 1, 40'h5A & 40'h7F, 1'b0);

    // Reset in the middle of the frame, while bit 20 is on DI.
    ri = 6'($urandom); ra = $urandom; rf = refFrame(ri, ra);
    expFrameQ.push_back(rf);
    index = ri; argument = ra; isStart = 1'b1;
    repeat (28) @(negedge clk);
    check("di_bit20", 64'(DI), 64'(rf[20]));
    #2 reset = 1'b1; isStart = 1'b0;
    #1;
    check("midrst_di", 64'(DI), 64'd1);
    check("midrst_busy", 64'(isBusy), 64'd0);
    check("midrst_finish", 64'(isFinish), 64'd0);
    check("midrst_rp", 64'(isRPFinish), 64'd0);
    check("midrst_response", 64'(response), 64'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    randCmd(5);

    for (int n = 0; n < 8; n++) randCmd($urandom_range(0, 24));

    fork
      randCmd(2);
      doDelay(5);
    join
    doDelay(0);
    doDelay($urandom_range(1, 15));
    doDelay(15);

    repeat (4) @(negedge clk);
    check("frame_queue_empty", 64'(expFrameQ.size()), 64'd0);
    check("resp_queue_empty", 64'(expRespQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sd_cmd_rp.md
# sd_cmd_rp

SPI-mode SD command engine with an auxiliary delay counter. It serialises a 48-bit SD command frame (start bits, 6-bit index, 32-bit argument, computed CRC7, end bit) onto DI. It then hunts DO for the card's response and captures R1, or R1 plus 32 bits for CMD8/CMD58. It sits between the SD read/init controllers and the card pins, clocked by the same clock that drives SCLK.

## Interface
Parameters:
- NCR_MAX, 128: maximum clocks to wait for the response start bit before timing out.
- COUNT_SIZE, 4: width of the delay counter and of `delayTimes`.

Ports:
- clk  in  1  system clock; also the SCLK seen by the card; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- index  in  6  command index; sampled on the accept edge.
- argument  in  32  command argument; sampled on the accept edge.
- isStart  in  1  level request. Accepted while idle; must stay high until `isRPFinish`.
- isBusy  out  1  high from the accept edge until return to idle.
- isFinish  out  1  frame fully transmitted; held until `isStart` is low.
- isRPFinish  out  1  response captured (or timed out); held until `isStart` is low.
- DI  out  1  serial command data to the card, MSB first; idles at 1.
- DO  in  1  serial response data from the card.
- response  out  40  captured response, right-aligned; valid while `isRPFinish` is high.
- delayStart  in  1  level request for the delay counter.
- delayTimes  in  COUNT_SIZE  delay length in clocks.
- delayFinish  out  1  delay elapsed; held until `delayStart` is low.

## Operation
- Reset values: DI=1, isBusy=0, isFinish=0, isRPFinish=0, response=0, delayFinish=0, all FSMs IDLE. A reset mid-frame aborts immediately.
- Frame layout: {2'b01, index, argument, crc7, 1'b1}.
  - crc7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
  - Check values: CMD0/arg 0 gives 0x95; CMD8/arg 0x1AA gives 0x87.
  - The CRC may be computed serially while shifting or combinationally at accept.
- FSM states: IDLE → SEND → WAIT → RECV → DONE → IDLE.
- IDLE: DI=1. If isStart=1, latch index/argument, build the frame, set isBusy=1 and go to SEND.
- SEND: drive one frame bit per clock, bit 47 first. After bit 0: DI=1, isFinish=1, go to WAIT.
- WAIT: DI held at 1. Sample DO each edge.
  - DO=0: that bit is R1 bit 7; go to RECV.
  - NCR_MAX edges with DO=1: timeout. Set response=40'h00_0000_00FF and isRPFinish=1, go to DONE.
- RECV: shift DO into a register MSB first.
  - Total length is 40 bits if the latched index is 8 or 58; otherwise 8 bits.
  - On the edge capturing the last bit: response = 40-bit value, or {32'h0, R1} for 8-bit responses. Set isRPFinish=1, go to DONE.
- DONE: hold outputs. When isStart=0, clear isFinish, isRPFinish and isBusy, go to IDLE. The response value is retained.
- isStart changes during SEND/WAIT/RECV are ignored.
- Delay FSM (independent of the command FSM):
  - IDLE with delayStart=1: load the counter with delayTimes, go to COUNT.
  - COUNT: decrement each edge. Set delayFinish=1 when the counter reaches 0; delayTimes=0 asserts on the next edge.
  - Hold delayFinish until delayStart=0, then return to IDLE.

## Timing
- Accept edge E0 (isStart=1 in IDLE): DI carries frame bit 47 after E0, bit 0 after edge E47.
- Edge E48: DI=1, isFinish=1, WAIT begins. The first DO sample is at edge E49.
- R1 response with start bit sampled at edge Es: isRPFinish=1 after Es+7. For 40-bit responses, after Es+39.
- Timeout: isRPFinish=1 after edge E48+NCR_MAX.
- The earliest next command is accepted 1 edge after isStart is observed low in DONE (IDLE is entered first).
- Delay: delayFinish rises delayTimes+1 edges after the edge that samples delayStart=1 in IDLE.

## Test plan
- CMD0, argument 0, DO replies 0x01 after 2 idle bytes → DI frame 0x400000000095; isFinish at E48; response=40'h0000000001.
- CMD8, argument 0x1AA, DO replies 01 00 00 01 AA → frame 0x48000001AA87; response=40'h01000001AA; isRPFinish 39 edges after the start bit.
- CMD17, argument 16, DO returns 0x00 → response==0; isBusy drops one edge after isStart is released.
- Any command with DO held at 1 → isRPFinish after exactly NCR_MAX WAIT edges; response=40'hFF.
- Reset asserted mid-SEND (bit 20) → DI=1 and all flags 0 immediately; the next isStart yields a complete correct frame.
- delayTimes=5 with delayStart raised → delayFinish rises 6 edges later and falls after delayStart drops. delayTimes=0 → finish after 1 edge.
